// File: rtl/imem_loader_if.sv
// imem_loader_if
//   Instruction-word stream between the boot/test source and the loader.
//   Signals:
//     WORD_IN    [31:0]  instruction word (big-endian byte order in memory)
//     WORD_VALID         WORD_IN / WORD_LAST are valid
//     WORD_LAST          this word ends the load session
//     WORD_READY         consumer accepts the word this cycle
//   Modports:
//     master : word source (drives data/valid/last, sees ready)
//     slave  : the loader  (sees data/valid/last, drives ready)
interface imem_loader_if;
    logic [31:0] WORD_IN;
    logic        WORD_VALID;
    logic        WORD_LAST;
    logic        WORD_READY;

    modport master (
        output WORD_IN,
        output WORD_VALID,
        output WORD_LAST,
        input  WORD_READY
    );

    modport slave (
        input  WORD_IN,
        input  WORD_VALID,
        input  WORD_LAST,
        output WORD_READY
    );
endinterface

// File: rtl/imem_loader.sv
// imem_loader
//   Fills the byte-wide instruction memory from a 32-bit word stream before
//   the PC leaves reset. Each accepted word becomes four consecutive byte
//   writes, most significant byte at the lowest address.
//   Ports:
//     CLK, RESET_N   clock (rising edge), asynchronous active-low reset
//     START          begin a session (only looked at in IDLE)
//     BASE_ADDR      first byte address, low two bits ignored
//     wif            word stream, slave side (WORD_READY driven here)
//     MEM_WE/ADDR/DATA  registered byte write port toward the memory
//     BUSY           session in progress
//     DONE           one-cycle end-of-session pulse
//     FULL           sticky: session stopped at the top of memory
//     WORD_COUNT     words fully written this session
//     CHECKSUM       (only with IMEM_LOADER_CHECKSUM_EN) mod-2^32 sum of
//                    accepted words, cleared on START
//   Optional feature macro: IMEM_LOADER_CHECKSUM_EN
module imem_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 9
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              START,
    input  logic [ADDR_W-1:0] BASE_ADDR,
    imem_loader_if.slave      wif,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [7:0]        MEM_DATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              FULL,
    output logic [CNT_W-1:0]  WORD_COUNT
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    output logic [31:0]       CHECKSUM
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_WRITE  = 2'd2,
        S_FIN    = 2'd3
    } state_t;

    // Address of the last word slot in memory; a non-LAST word written here ends the session.
    localparam logic [ADDR_W-1:0] TOP_WORD  = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [ADDR_W-1:0] WORD_STEP = {{(ADDR_W-3){1'b0}}, 3'b100};
    localparam logic [ADDR_W-1:0] ALIGN_MSK = {{(ADDR_W-2){1'b1}}, 2'b00};
    localparam logic [CNT_W-1:0]  CNT_ONE   = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [31:0]         word_q, word_d;
    logic                last_q, last_d;
    logic [1:0]          idx_q, idx_d;
    logic [1:0]          idx_inc_s;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                full_q, full_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [7:0]          mem_data_q, mem_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0]         sum_q, sum_d;
`endif

    // Big-endian byte lane select: lane 0 is bits [31:24].
    function automatic logic [7:0] byte_of(input logic [31:0] w, input logic [1:0] i);
        case (i)
            2'd0:    return w[31:24];
            2'd1:    return w[23:16];
            2'd2:    return w[15:8];
            default: return w[7:0];
        endcase
    endfunction

    assign idx_inc_s = idx_q + 2'd1;

    // Next-state and write-port computation; the write port is registered so each byte appears one cycle after the decision.
    always_comb begin
        state_d    = state_q;
        waddr_d    = waddr_q;
        word_d     = word_q;
        last_d     = last_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        full_d     = full_q;
        mem_we_d   = 1'b0;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (START) begin
                    waddr_d = BASE_ADDR & ALIGN_MSK;
                    cnt_d   = {CNT_W{1'b0}};
                    full_d  = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d   = 32'd0;
`endif
                    state_d = S_ACCEPT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ACCEPT: begin
                if (wif.WORD_VALID) begin
                    word_d     = wif.WORD_IN;
                    last_d     = wif.WORD_LAST;
                    idx_d      = 2'd0;
                    mem_we_d   = 1'b1;
                    mem_addr_d = waddr_q;
                    mem_data_d = byte_of(wif.WORD_IN, 2'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
                    sum_d      = sum_q + wif.WORD_IN;
`endif
                    state_d    = S_WRITE;
                end else begin
                    state_d = S_ACCEPT;
                end
            end
            S_WRITE: begin
                if (idx_q != 2'd3) begin
                    idx_d      = idx_inc_s;
                    mem_we_d   = 1'b1;
                    mem_addr_d = waddr_q | {{(ADDR_W-2){1'b0}}, idx_inc_s};
                    mem_data_d = byte_of(word_q, idx_inc_s);
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                    // LAST wins over FULL when the final word lands in the top slot.
                    if (last_q) begin
                        state_d = S_FIN;
                    end else if (waddr_q == TOP_WORD) begin
                        full_d  = 1'b1;
                        state_d = S_FIN;
                    end else begin
                        waddr_d = waddr_q + WORD_STEP;
                        state_d = S_ACCEPT;
                    end
                end
            end
            S_FIN: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears the write strobe at once so a torn word stops immediately.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state_q    <= S_IDLE;
            waddr_q    <= {ADDR_W{1'b0}};
            word_q     <= 32'd0;
            last_q     <= 1'b0;
            idx_q      <= 2'd0;
            cnt_q      <= {CNT_W{1'b0}};
            full_q     <= 1'b0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= {ADDR_W{1'b0}};
            mem_data_q <= 8'd0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= 32'd0;
`endif
        end else begin
            state_q    <= state_d;
            waddr_q    <= waddr_d;
            word_q     <= word_d;
            last_q     <= last_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            full_q     <= full_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_data_q <= mem_data_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            sum_q      <= sum_d;
`endif
        end
    end

    assign wif.WORD_READY = (state_q == S_ACCEPT);
    assign BUSY           = (state_q != S_IDLE);
    assign DONE           = (state_q == S_FIN);
    assign FULL           = full_q;
    assign WORD_COUNT     = cnt_q;
    assign MEM_WE         = mem_we_q;
    assign MEM_ADDR       = mem_addr_q;
    assign MEM_DATA       = mem_data_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    assign CHECKSUM       = sum_q;
`endif

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader
//   Randomized and directed load sessions against a queue-based reference:
//   the expected byte writes, word count, FULL flag and session length are
//   derived from the word list, base address and stall plan alone.
module tb_imem_loader;

    logic        CLK;
    logic        RESET_N;
    logic        START;
    logic [9:0]  BASE_ADDR;
    logic        MEM_WE;
    logic [9:0]  MEM_ADDR;
    logic [7:0]  MEM_DATA;
    logic        BUSY;
    logic        DONE;
    logic        FULL;
    logic [8:0]  WORD_COUNT;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [31:0] CHECKSUM;
`endif

    imem_loader_if wif ();

    imem_loader #(.ADDR_W(10), .CNT_W(9)) dut (
        .CLK        (CLK),
        .RESET_N    (RESET_N),
        .START      (START),
        .BASE_ADDR  (BASE_ADDR),
        .wif        (wif),
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_DATA   (MEM_DATA),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .FULL       (FULL),
        .WORD_COUNT (WORD_COUNT)
`ifdef IMEM_LOADER_CHECKSUM_EN
        ,
        .CHECKSUM   (CHECKSUM)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_pass   = 0;

    bit [31:0] words[$];
    int        plan[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v)
            $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp_v);
        else
            n_pass++;
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_we"},    32'(MEM_WE), 32'd0);
        check_eq({tag, "_addr"},  32'(MEM_ADDR), 32'd0);
        check_eq({tag, "_data"},  32'(MEM_DATA), 32'd0);
        check_eq({tag, "_ready"}, 32'(wif.WORD_READY), 32'd0);
        check_eq({tag, "_busy"},  32'(BUSY), 32'd0);
        check_eq({tag, "_done"},  32'(DONE), 32'd0);
        check_eq({tag, "_full"},  32'(FULL), 32'd0);
        check_eq({tag, "_count"}, 32'(WORD_COUNT), 32'd0);
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_eq({tag, "_csum"},  CHECKSUM, 32'd0);
`endif
    endtask

    // One full session: plan[w] = ACCEPT cycles with VALID low before word w.
    task automatic run_session(input logic [9:0] base, input bit last_on_final);
        int        n;
        int        exp_a[$];
        int        exp_d[$];
        int        exp_words, total_stall, wi, stall, cyc, first_we, done_cyc, waits;
        bit        exp_full, done_seen, prev_we, rdy, acc;
        bit [31:0] exp_sum;

        n = words.size();
        exp_words = 0; exp_full = 1'b0; exp_sum = 32'd0; total_stall = 0;
        for (int w = 0; w < n; w++) begin
            int a;
            a = (int'(base) / 4) * 4 + 4 * w;
            for (int b = 0; b < 4; b++) begin
                exp_a.push_back(a + b);
                exp_d.push_back(int'((words[w] >> (24 - 8 * b)) & 32'hFF));
            end
            exp_words++;
            exp_sum += words[w];
            total_stall += plan[w];
            if (last_on_final && w == n - 1) break;
            if (a == 1020) begin exp_full = 1'b1; break; end
        end

        @(negedge CLK);
        START          = 1'b1;
        BASE_ADDR      = base;
        wif.WORD_VALID = 1'b1;
        wif.WORD_IN    = words[0];
        wif.WORD_LAST  = last_on_final && (n == 1);
        @(negedge CLK);
        START = 1'b0;
        check_eq("start_busy",  32'(BUSY), 32'd1);
        check_eq("start_ready", 32'(wif.WORD_READY), 32'd1);
        check_eq("start_count", 32'(WORD_COUNT), 32'd0);
        check_eq("start_full",  32'(FULL), 32'd0);

        wi = 0; stall = 0; cyc = 0; first_we = -1; done_cyc = 0; waits = 0;
        done_seen = 1'b0; prev_we = 1'b0;
        while (!done_seen && cyc < 3000) begin
            if (MEM_WE) begin
                if (first_we < 0) first_we = cyc;
                if (exp_a.size() == 0) begin
                    check_eq("extra_write", 32'(MEM_ADDR), 32'hFFFFFFFF);
                end else begin
                    check_eq("write_addr", 32'(MEM_ADDR), 32'(exp_a.pop_front()));
                    check_eq("write_data", 32'(MEM_DATA), 32'(exp_d.pop_front()));
                end
            end
            if (DONE) begin
                done_seen = 1'b1;
                done_cyc  = cyc;
                check_eq("writes_left_at_done", 32'(exp_a.size()), 32'd0);
                check_eq("done_after_last_byte", 32'(prev_we), 32'd1);
                check_eq("word_count", 32'(WORD_COUNT), 32'(exp_words));
                check_eq("full_flag", 32'(FULL), 32'(exp_full));
                check_eq("busy_in_fin", 32'(BUSY), 32'd1);
`ifdef IMEM_LOADER_CHECKSUM_EN
                check_eq("checksum", CHECKSUM, exp_sum);
`endif
            end
            prev_we = MEM_WE;
            rdy = wif.WORD_READY;
            acc = rdy && wif.WORD_VALID;
            if (rdy && !wif.WORD_VALID) waits++;
            @(posedge CLK);
            #1;
            if (acc) begin
                wi++;
                wif.WORD_VALID = 1'b0;
                stall = (wi < n) ? plan[wi] : 0;
            end else if (!wif.WORD_VALID && rdy && stall > 0) begin
                stall--;
            end
            if (!wif.WORD_VALID && wi < n && stall == 0) begin
                wif.WORD_VALID = 1'b1;
                wif.WORD_IN    = words[wi];
                wif.WORD_LAST  = last_on_final && (wi == n - 1);
            end
            @(negedge CLK);
            cyc++;
        end

        check_eq("done_seen", 32'(done_seen), 32'd1);
        check_eq("first_write_latency", 32'(first_we), 32'd1);
        check_eq("session_length", 32'(done_cyc - first_we), 32'(5 * exp_words - 1 + total_stall));
        check_eq("ready_wait_cycles", 32'(waits), 32'(total_stall));
        check_eq("accepted_words", 32'(wi), 32'(exp_words));
        check_eq("busy_after_done", 32'(BUSY), 32'd0);
        check_eq("done_one_cycle", 32'(DONE), 32'd0);
        repeat (3) @(negedge CLK);
        check_eq("ready_low_in_idle", 32'(wif.WORD_READY), 32'd0);
        check_eq("count_held", 32'(WORD_COUNT), 32'(exp_words));
        check_eq("full_sticky", 32'(FULL), 32'(exp_full));
`ifdef IMEM_LOADER_CHECKSUM_EN
        check_eq("checksum_held", CHECKSUM, exp_sum);
`endif
        wif.WORD_VALID = 1'b0;
        wif.WORD_LAST  = 1'b0;
    endtask

    initial begin
        bit found;
        int k;

        RESET_N = 1'b0; START = 1'b0; BASE_ADDR = 10'd0;
        wif.WORD_IN = 32'd0; wif.WORD_VALID = 1'b0; wif.WORD_LAST = 1'b0;
        #1;
        check_reset_values("reset");
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);

        // Single word with LAST.
        words = '{32'h08011000}; plan = '{0};
        run_session(10'd0, 1'b1);

        // Six-word program, base 0x006, valid dropped 3 cycles before word 3.
        words = '{32'h08011000, 32'h00642800, 32'h04C74000,
                  32'h19895800, 32'h1D8D7000, 32'h31F08800};
        plan  = '{0, 0, 3, 0, 0, 0};
        run_session(10'h006, 1'b1);

        // Top of memory: third word must never be accepted.
        words = '{32'hA1B2C3D4, 32'h55667788, 32'hDEADBEEF}; plan = '{0, 0, 0};
        run_session(10'd1016, 1'b0);

        // Random sessions ending in LAST.
        for (int s = 0; s < 6; s++) begin
            words.delete(); plan.delete();
            k = $urandom_range(1, 6);
            for (int w = 0; w < k; w++) begin
                words.push_back($urandom);
                plan.push_back((w == 0) ? 0 : $urandom_range(0, 2));
            end
            run_session(10'($urandom_range(0, 1023)), 1'b1);
        end

        // Random sessions running into the top of memory.
        for (int s = 0; s < 2; s++) begin
            words.delete(); plan.delete();
            k = $urandom_range(1, 3);
            for (int w = 0; w < k + 1; w++) begin
                words.push_back($urandom);
                plan.push_back((w == 0) ? 0 : $urandom_range(0, 2));
            end
            run_session(10'(1024 - 4 * k + $urandom_range(0, 3)), 1'b0);
        end

        // Reset during byte index 2, then reload.
        @(negedge CLK);
        START = 1'b1; BASE_ADDR = 10'd40;
        wif.WORD_VALID = 1'b1; wif.WORD_IN = 32'h11223344; wif.WORD_LAST = 1'b0;
        @(negedge CLK);
        START = 1'b0;
        found = 1'b0;
        for (int c = 0; c < 20 && !found; c++) begin
            @(negedge CLK);
            if (MEM_WE && MEM_ADDR[1:0] == 2'd2) found = 1'b1;
        end
        check_eq("reached_byte2", 32'(found), 32'd1);
        check_eq("byte2_data", 32'(MEM_DATA), 32'h33);
        #2;
        RESET_N = 1'b0;
        #1;
        check_reset_values("async_reset");
        wif.WORD_VALID = 1'b0;
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        check_eq("idle_after_reset", 32'(BUSY), 32'd0);
        words = '{32'hCAFEF00D, 32'h0BADC0DE}; plan = '{0, 1};
        run_session(10'd40, 1'b1);

`ifdef IMEM_LOADER_CHECKSUM_EN
        words = '{32'hFFFFFFFF, 32'h00000002}; plan = '{0, 0};
        run_session(10'd100, 1'b1);
        check_eq("checksum_wrap", CHECKSUM, 32'h00000001);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
